// File: rtl/ex_mem_pkg.sv
// ex_mem_pkg: shared types and helpers for the EX->MEM pipeline stage.
// The payload struct is declared at the default core widths; wider cores pack
// the same field order through payload_w() and a plain concatenation.
package ex_mem_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 6;

  // Field order (MSB first) is the packing order used by ex_mem_stage.
  typedef struct packed {
    logic                  halted;
    logic                  data_rw;
    logic                  mem_write;
    logic [DATA_W_DEF-1:0] alu_output;
    logic [ADDR_W_DEF-1:0] write_addr;
  } ex_mem_payload_t;

  localparam int PAYLOAD_W = $bits(ex_mem_payload_t);

  function automatic int payload_w(input int data_w, input int addr_w);
    return 3 + data_w + addr_w;
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf: generic valid/ready pipeline register with optional skid entry.
//   clk, rst_n      clock / async active-low reset
//   flush_i         squash all held entries (wins over any transfer)
//   in_valid_i      upstream valid
//   in_ready_o      upstream ready (registered when SKID_EN = 1)
//   in_data_i       upstream payload
//   out_valid_o     downstream valid (main entry)
//   out_ready_i     downstream ready
//   out_data_o      downstream payload (ungated, main entry)
//   occupancy_o     entries held (0..2)
module pipe_skid_buf #(
  parameter int WIDTH   = 8,
  parameter int SKID_EN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o,
  output logic [1:0]       occupancy_o
);

  logic             main_valid_q, main_valid_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic             accept;
  logic             drain;

  assign accept      = in_valid_i & in_ready_o;
  assign drain       = main_valid_q & out_ready_i;
  assign out_valid_o = main_valid_q;
  assign out_data_o  = main_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      main_q       <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_q       <= main_d;
    end
  end

  if (SKID_EN != 0) begin : g_skid
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_q, skid_d;

    // Ready depends only on registered state, breaking the out_ready path.
    assign in_ready_o  = ~skid_valid_q;
    assign occupancy_o = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

    always_comb begin
      main_valid_d = main_valid_q;
      main_d       = main_q;
      skid_valid_d = skid_valid_q;
      skid_d       = skid_q;
      if (flush_i) begin
        main_valid_d = 1'b0;
        skid_valid_d = 1'b0;
      end else begin
        case ({main_valid_q, skid_valid_q})
          2'b00: begin
            if (accept) begin
              main_valid_d = 1'b1;
              main_d       = in_data_i;
            end
          end
          2'b10: begin
            if (drain && accept) begin
              main_d = in_data_i;
            end else if (drain) begin
              main_valid_d = 1'b0;
            end else if (accept) begin
              skid_valid_d = 1'b1;
              skid_d       = in_data_i;
            end
          end
          2'b11: begin
            // No accept possible here: in_ready is low while skid holds data.
            if (drain) begin
              main_d       = skid_q;
              skid_valid_d = 1'b0;
            end
          end
          default: begin
          end
        endcase
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        skid_valid_q <= 1'b0;
        skid_q       <= '0;
      end else begin
        skid_valid_q <= skid_valid_d;
        skid_q       <= skid_d;
      end
    end
  end else begin : g_single
    assign in_ready_o  = ~main_valid_q | out_ready_i;
    assign occupancy_o = {1'b0, main_valid_q};

    always_comb begin
      main_valid_d = main_valid_q;
      main_d       = main_q;
      if (flush_i) begin
        main_valid_d = 1'b0;
      end else if (accept) begin
        main_valid_d = 1'b1;
        main_d       = in_data_i;
      end else if (drain) begin
        main_valid_d = 1'b0;
      end
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: EX->MEM pipeline stage with valid/ready handshake, skid
// buffer, flush and sticky halt tracking.
//   clk, rst_n                      clock / async active-low reset
//   in_valid, in_ready              upstream handshake
//   in_halted, in_data_rw,
//   in_mem_write, in_alu_output,
//   in_write_addr                   upstream payload
//   flush                           squash held entries, clear halt_seen
//   out_valid, out_ready            downstream handshake
//   out_*                           payload, forced to 0 while out_valid = 0
//   halt_seen                       sticky: an unflushed HALT was accepted
//   occupancy                       entries held (0..2)
module ex_mem_stage
  import ex_mem_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 6,
  parameter int SKID_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_halted,
  input  logic              in_data_rw,
  input  logic              in_mem_write,
  input  logic [DATA_W-1:0] in_alu_output,
  input  logic [ADDR_W-1:0] in_write_addr,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_halted,
  output logic              out_data_rw,
  output logic              out_mem_write,
  output logic [DATA_W-1:0] out_alu_output,
  output logic [ADDR_W-1:0] out_write_addr,
  output logic              halt_seen,
  output logic [1:0]        occupancy
);

  localparam int PW = payload_w(DATA_W, ADDR_W);

  logic          halt_seen_q, halt_seen_d;
  logic          buf_in_ready;
  logic          buf_out_valid;
  logic          accept;
  logic [PW-1:0] in_pl;
  logic [PW-1:0] out_pl;

  logic              pl_halted;
  logic              pl_data_rw;
  logic              pl_mem_write;
  logic [DATA_W-1:0] pl_alu_output;
  logic [ADDR_W-1:0] pl_write_addr;

  assign in_ready = buf_in_ready & ~halt_seen_q;
  assign accept   = in_valid & in_ready;

  assign in_pl = {in_halted, in_data_rw, in_mem_write, in_alu_output, in_write_addr};

  pipe_skid_buf #(
    .WIDTH   (PW),
    .SKID_EN (SKID_EN)
  ) u_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush),
    // Halt blocks entry here so the buffer never sees an accept we refuse.
    .in_valid_i  (in_valid & ~halt_seen_q),
    .in_ready_o  (buf_in_ready),
    .in_data_i   (in_pl),
    .out_valid_o (buf_out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_pl),
    .occupancy_o (occupancy)
  );

  always_comb begin
    halt_seen_d = halt_seen_q;
    if (flush) begin
      halt_seen_d = 1'b0;
    end else if (accept && in_halted) begin
      halt_seen_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halt_seen_q <= 1'b0;
    end else begin
      halt_seen_q <= halt_seen_d;
    end
  end

  assign {pl_halted, pl_data_rw, pl_mem_write, pl_alu_output, pl_write_addr} = out_pl;

  // Stale payload left behind by flush or drain stays invisible downstream.
  assign out_valid      = buf_out_valid;
  assign out_halted     = buf_out_valid & pl_halted;
  assign out_data_rw    = buf_out_valid & pl_data_rw;
  assign out_mem_write  = buf_out_valid & pl_mem_write;
  assign out_alu_output = buf_out_valid ? pl_alu_output : '0;
  assign out_write_addr = buf_out_valid ? pl_write_addr : '0;
  assign halt_seen      = halt_seen_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: two instances share one stimulus stream,
// dut0 = defaults (skid, 8-bit), dut1 = SKID_EN 0, DATA_W 16.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_halted, in_data_rw, in_mem_write, flush, out_ready;
  logic [15:0] in_alu;
  logic [7:0]  in_alu8;
  logic [5:0]  in_addr;

  logic        o0_in_ready, o0_valid, o0_halted, o0_rw, o0_mw, o0_halt_seen;
  logic [7:0]  o0_alu;
  logic [5:0]  o0_addr;
  logic [1:0]  o0_occ;
  logic        o1_in_ready, o1_valid, o1_halted, o1_rw, o1_mw, o1_halt_seen;
  logic [15:0] o1_alu;
  logic [5:0]  o1_addr;
  logic [1:0]  o1_occ;

  int n_checks = 0;
  int n_errors = 0;

  assign in_alu8 = in_alu[7:0];

  always #5 clk = ~clk;

  ex_mem_stage dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(o0_in_ready),
    .in_halted(in_halted), .in_data_rw(in_data_rw), .in_mem_write(in_mem_write),
    .in_alu_output(in_alu8), .in_write_addr(in_addr), .flush(flush),
    .out_valid(o0_valid), .out_ready(out_ready), .out_halted(o0_halted),
    .out_data_rw(o0_rw), .out_mem_write(o0_mw), .out_alu_output(o0_alu),
    .out_write_addr(o0_addr), .halt_seen(o0_halt_seen), .occupancy(o0_occ));

  ex_mem_stage #(.DATA_W(16), .ADDR_W(6), .SKID_EN(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(o1_in_ready),
    .in_halted(in_halted), .in_data_rw(in_data_rw), .in_mem_write(in_mem_write),
    .in_alu_output(in_alu), .in_write_addr(in_addr), .flush(flush),
    .out_valid(o1_valid), .out_ready(out_ready), .out_halted(o1_halted),
    .out_data_rw(o1_rw), .out_mem_write(o1_mw), .out_alu_output(o1_alu),
    .out_write_addr(o1_addr), .halt_seen(o1_halt_seen), .occupancy(o1_occ));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: a bounded FIFO per instance ----------
  typedef struct packed {
    logic        h;
    logic        rw;
    logic        mw;
    logic [15:0] alu;
    logic [5:0]  addr;
  } pl_t;

  pl_t m_e [2][2];
  int  m_n [2];
  bit  m_h [2];

  // dut0 holds up to two entries; dut1 holds one and takes a new one only
  // when empty or when its entry leaves the same cycle.
  function automatic bit m_rdy(input int d);
    if (m_h[d]) return 1'b0;
    if (d == 0) return m_n[0] < 2;
    return (m_n[1] == 0) || out_ready;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        m_n[d] = 0;
        m_h[d] = 1'b0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        bit   rdy;
        pl_t  p;
        rdy = m_rdy(d);
        if (flush) begin
          m_n[d] = 0;
          m_h[d] = 1'b0;
        end else begin
          if (m_n[d] > 0 && out_ready) begin
            m_e[d][0] = m_e[d][1];
            m_n[d]--;
          end
          if (in_valid && rdy) begin
            p.h    = in_halted;
            p.rw   = in_data_rw;
            p.mw   = in_mem_write;
            p.alu  = (d == 0) ? {8'h00, in_alu[7:0]} : in_alu;
            p.addr = in_addr;
            m_e[d][m_n[d]] = p;
            m_n[d]++;
            if (in_halted) m_h[d] = 1'b1;
          end
        end
      end
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin
    pl_t e0, e1;
    e0 = (m_n[0] > 0) ? m_e[0][0] : '0;
    e1 = (m_n[1] > 0) ? m_e[1][0] : '0;
    chk("d0_valid", {31'b0, o0_valid}, {31'b0, m_n[0] > 0});
    chk("d0_occ", {30'b0, o0_occ}, m_n[0]);
    chk("d0_in_ready", {31'b0, o0_in_ready}, {31'b0, m_rdy(0)});
    chk("d0_halt_seen", {31'b0, o0_halt_seen}, {31'b0, m_h[0]});
    chk("d0_payload", {15'b0, o0_halted, o0_rw, o0_mw, 8'h00, o0_alu, o0_addr}, {7'b0, e0});
    chk("d1_valid", {31'b0, o1_valid}, {31'b0, m_n[1] > 0});
    chk("d1_occ", {30'b0, o1_occ}, m_n[1]);
    chk("d1_in_ready", {31'b0, o1_in_ready}, {31'b0, m_rdy(1)});
    chk("d1_halt_seen", {31'b0, o1_halt_seen}, {31'b0, m_h[1]});
    chk("d1_payload", {7'b0, o1_halted, o1_rw, o1_mw, o1_alu, o1_addr}, {7'b0, e1});
  end

  // ---------------- directed stimulus with literal expectations -------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [15:0] a, input logic [5:0] wa,
                       input logic h, input logic rw, input logic mw);
    in_valid     = v;
    in_alu       = a;
    in_addr      = wa;
    in_halted    = h;
    in_data_rw   = rw;
    in_mem_write = mw;
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 16'h0, 6'h0, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    chk("rst_valid", {31'b0, o0_valid}, 0);
    chk("rst_occ", {30'b0, o0_occ}, 0);
    chk("rst_halt", {31'b0, o0_halt_seen}, 0);
    chk("rst_alu", {24'b0, o0_alu}, 0);
    rst_n = 1'b1;

    // 1: single transfer
    drive(1'b1, 16'h003C, 6'd5, 1'b0, 1'b1, 1'b0);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("t1_valid", {31'b0, o0_valid}, 1);
    chk("t1_alu", {24'b0, o0_alu}, 32'h3C);
    chk("t1_addr", {26'b0, o0_addr}, 5);
    chk("t1_rw", {31'b0, o0_rw}, 1);
    chk("t1_occ", {30'b0, o0_occ}, 1);
    tick();
    chk("t1_occ_drained", {30'b0, o0_occ}, 0);
    chk("t1_valid_drained", {31'b0, o0_valid}, 0);

    // 2: backpressure
    out_ready = 1'b0;
    drive(1'b1, 16'h0011, 6'd1, 1'b0, 1'b0, 1'b1);
    tick();
    in_alu = 16'h0022;
    in_addr = 6'd2;
    tick();
    in_valid = 1'b0;
    chk("t2_occ_full", {30'b0, o0_occ}, 2);
    chk("t2_ready_full", {31'b0, o0_in_ready}, 0);
    chk("t2_head_A", {24'b0, o0_alu}, 32'h11);
    out_ready = 1'b1;
    tick();
    chk("t2_head_B", {24'b0, o0_alu}, 32'h22);
    chk("t2_ready_back", {31'b0, o0_in_ready}, 1);
    tick();
    chk("t2_empty", {30'b0, o0_occ}, 0);

    // 3: full rate stream
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, 16'(i), 6'(i), 1'b0, i[0], i[1]);
      tick();
      chk("t3_valid", {31'b0, o0_valid}, 1);
      chk("t3_alu", {24'b0, o0_alu}, i);
      chk("t3_ready", {31'b0, o0_in_ready}, 1);
      chk("t3_d1_alu", {16'b0, o1_alu}, i);
    end
    in_valid = 1'b0;
    tick();

    // 4: flush while full with concurrent input
    out_ready = 1'b0;
    drive(1'b1, 16'h0031, 6'd3, 1'b0, 1'b0, 1'b0);
    tick();
    in_alu = 16'h0032;
    tick();
    chk("t4_occ_full", {30'b0, o0_occ}, 2);
    flush = 1'b1;
    drive(1'b1, 16'h0077, 6'd7, 1'b0, 1'b1, 1'b1);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("t4_valid", {31'b0, o0_valid}, 0);
    chk("t4_occ", {30'b0, o0_occ}, 0);
    chk("t4_alu", {24'b0, o0_alu}, 0);
    chk("t4_addr", {26'b0, o0_addr}, 0);
    out_ready = 1'b1;
    tick();
    chk("t4_no_77", {31'b0, o0_valid}, 0);

    // 5: halt
    out_ready = 1'b0;
    drive(1'b1, 16'h0005, 6'd4, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 16'h0006, 6'd6, 1'b0, 1'b0, 1'b0);
    chk("t5_halt_seen", {31'b0, o0_halt_seen}, 1);
    chk("t5_ready", {31'b0, o0_in_ready}, 0);
    chk("t5_out_halted", {31'b0, o0_halted}, 1);
    chk("t5_alu", {24'b0, o0_alu}, 5);
    tick();
    chk("t5_occ_hold", {30'b0, o0_occ}, 1);
    out_ready = 1'b1;
    tick();
    chk("t5_drained", {31'b0, o0_valid}, 0);
    tick();
    chk("t5_no_06", {31'b0, o0_valid}, 0);
    in_valid = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("t5_halt_clear", {31'b0, o0_halt_seen}, 0);
    chk("t5_ready_back", {31'b0, o0_in_ready}, 1);

    // 6: asynchronous reset with both entries held
    out_ready = 1'b0;
    drive(1'b1, 16'h0041, 6'd1, 1'b0, 1'b1, 1'b1);
    tick();
    in_alu = 16'h0042;
    tick();
    in_valid = 1'b0;
    chk("t6_occ_full", {30'b0, o0_occ}, 2);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", {31'b0, o0_valid}, 0);
    chk("t6_async_occ", {30'b0, o0_occ}, 0);
    chk("t6_async_alu", {24'b0, o0_alu}, 0);
    chk("t6_async_rw", {31'b0, o0_rw}, 0);
    chk("t6_async_d1_valid", {31'b0, o1_valid}, 0);
    tick();
    rst_n = 1'b1;

    // 6b: 16-bit single-entry instance
    out_ready = 1'b1;
    drive(1'b1, 16'hBEEF, 6'd9, 1'b0, 1'b0, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("t6b_valid", {31'b0, o1_valid}, 1);
    chk("t6b_alu", {16'b0, o1_alu}, 32'hBEEF);
    chk("t6b_d0_alu", {24'b0, o0_alu}, 32'hEF);
    out_ready = 1'b0;
    #1;
    chk("t6b_ready_low", {31'b0, o1_in_ready}, 0);
    out_ready = 1'b1;
    #1;
    chk("t6b_ready_high", {31'b0, o1_in_ready}, 1);
    tick();
    chk("t6b_drained", {31'b0, o1_valid}, 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
